// File: rtl/rfBlackWidowPkg.sv
// Shared types for the BlackWidow predicate register file.
// Index fields are sized for the largest supported file; narrower indices zero-extend.
package rfBlackWidowPkg;
   localparam int PRED_IDX_W = 16;
   typedef logic [PRED_IDX_W-1:0] pred_idx_t;

   localparam pred_idx_t PRED_ZERO = pred_idx_t'(0);
   localparam pred_idx_t PRED_ONE  = pred_idx_t'(1);

   typedef struct packed {
      pred_idx_t pRt1;
      pred_idx_t pRt2;
      logic      wr;
      logic      res;
   } pred_fwd_t;
endpackage

// File: rtl/bw_pred_regfile_fwd_sel.sv
// Per-read-port priority selector: constants, forwarding stages (youngest first),
// writeback, then storage. hit flags that a non-storage source supplied the value.
module bw_pred_fwd_sel
   import rfBlackWidowPkg::*;
#(
   parameter int NFWD = 2
) (
   input  pred_idx_t                pRn,
   input  pred_fwd_t [NFWD-1:0]     fwd,
   input  pred_fwd_t                wb,
   input  logic                     stor_bit,
   output logic                     o,
   output logic                     hit
);
   always_comb begin
      o   = 1'b0;
      hit = 1'b0;
      if (pRn == PRED_ZERO) begin
         o   = 1'b0;
         hit = 1'b1;
      end else if (pRn == PRED_ONE) begin
         o   = 1'b1;
         hit = 1'b1;
      end else begin
         for (int s = 0; s < NFWD; s++) begin
            if (!hit && fwd[s].wr) begin
               if (pRn == fwd[s].pRt1) begin
                  o   = fwd[s].res;
                  hit = 1'b1;
               end else if (pRn == fwd[s].pRt2) begin
                  o   = ~fwd[s].res;
                  hit = 1'b1;
               end
            end
         end
         if (!hit && wb.wr) begin
            if (pRn == wb.pRt1) begin
               o   = wb.res;
               hit = 1'b1;
            end else if (pRn == wb.pRt2) begin
               o   = ~wb.res;
               hit = 1'b1;
            end
         end
         if (!hit) o = stor_bit;
      end
   end
endmodule

// File: rtl/bw_pred_regfile_fwd.sv
// Predicate register file with forwarding network and pending scoreboard.
// Optional context save/restore port set enabled by BW_PRED_BULK_EN.
module bw_pred_regfile_fwd
   import rfBlackWidowPkg::*;
#(
   parameter  int NPREG = 64,
   parameter  int NRD   = 3,
   parameter  int NFWD  = 2,
   localparam int AW    = $clog2(NPREG)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NRD-1:0][AW-1:0]     rd_pRn,
   output logic [NRD-1:0]             rd_o,
   output logic [NRD-1:0]             rd_rdy,
   input  logic [NFWD-1:0][AW-1:0]    fwd_pRt1,
   input  logic [NFWD-1:0][AW-1:0]    fwd_pRt2,
   input  logic [NFWD-1:0]            fwd_wr,
   input  logic [NFWD-1:0]            fwd_res,
   input  logic [AW-1:0]              wb_pRt1,
   input  logic [AW-1:0]              wb_pRt2,
   input  logic                       wb_wr,
   input  logic                       wb_res,
   input  logic [AW-1:0]              iss_pRt1,
   input  logic [AW-1:0]              iss_pRt2,
   input  logic                       iss_v,
   input  logic                       flush,
`ifdef BW_PRED_BULK_EN
   output logic [NPREG-1:0]           bulk_o,
   input  logic [NPREG-1:0]           bulk_i,
   input  logic                       bulk_wr,
`endif
   output logic [AW:0]                pend_cnt
);
   logic [NPREG-1:0] stor_q, stor_d;
   logic [NPREG-1:0] pend_q, pend_d;
   logic [AW:0]      pend_cnt_q, pend_cnt_d;

   pred_fwd_t [NFWD-1:0] fwd_bus;
   pred_fwd_t            wb_bus;

   always_comb begin
      for (int s = 0; s < NFWD; s++) begin
         fwd_bus[s].pRt1 = pred_idx_t'(fwd_pRt1[s]);
         fwd_bus[s].pRt2 = pred_idx_t'(fwd_pRt2[s]);
         fwd_bus[s].wr   = fwd_wr[s];
         fwd_bus[s].res  = fwd_res[s];
      end
      wb_bus.pRt1 = pred_idx_t'(wb_pRt1);
      wb_bus.pRt2 = pred_idx_t'(wb_pRt2);
      wb_bus.wr   = wb_wr;
      wb_bus.res  = wb_res;
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic hit;
      bw_pred_fwd_sel #(.NFWD(NFWD)) u_sel (
         .pRn      (pred_idx_t'(rd_pRn[i])),
         .fwd      (fwd_bus),
         .wb       (wb_bus),
         .stor_bit (stor_q[rd_pRn[i]]),
         .o        (rd_o[i]),
         .hit      (hit)
      );
      assign rd_rdy[i] = hit | ~pend_q[rd_pRn[i]];
   end

   // Clear-before-set ordering lets a same-cycle issue reclaim a register being retired.
   always_comb begin
      stor_d = stor_q;
      pend_d = pend_q;
      if (wb_wr) begin
         stor_d[wb_pRt2] = ~wb_res;
         stor_d[wb_pRt1] = wb_res;
      end
      if (flush) pend_d = '0;
      if (wb_wr) begin
         pend_d[wb_pRt1] = 1'b0;
         pend_d[wb_pRt2] = 1'b0;
      end
      if (iss_v) begin
         pend_d[iss_pRt1] = 1'b1;
         pend_d[iss_pRt2] = 1'b1;
      end
`ifdef BW_PRED_BULK_EN
      if (bulk_wr) begin
         stor_d = bulk_i;
         pend_d = '0;
      end
`endif
      stor_d[0] = 1'b0;
      stor_d[1] = 1'b1;
      pend_d[0] = 1'b0;
      pend_d[1] = 1'b0;
   end

   always_comb begin
      pend_cnt_d = '0;
      for (int i = 0; i < NPREG; i++)
         pend_cnt_d = pend_cnt_d + {{AW{1'b0}}, pend_d[i]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stor_q     <= NPREG'(2);
         pend_q     <= '0;
         pend_cnt_q <= '0;
      end else begin
         stor_q     <= stor_d;
         pend_q     <= pend_d;
         pend_cnt_q <= pend_cnt_d;
      end
   end

   assign pend_cnt = pend_cnt_q;
`ifdef BW_PRED_BULK_EN
   assign bulk_o = stor_q;
`endif
endmodule

// File: tb/tb_bw_pred_regfile_fwd.sv
// Directed bench for bw_pred_regfile_fwd with a behavioural reference model.
module tb_bw_pred_regfile_fwd;
   localparam int NPREG = 64;
   localparam int NRD   = 3;
   localparam int NFWD  = 2;
   localparam int AW    = $clog2(NPREG);

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [NRD-1:0][AW-1:0]  rd_pRn;
   logic [NRD-1:0]          rd_o, rd_rdy;
   logic [NFWD-1:0][AW-1:0] fwd_pRt1, fwd_pRt2;
   logic [NFWD-1:0]         fwd_wr, fwd_res;
   logic [AW-1:0]           wb_pRt1, wb_pRt2, iss_pRt1, iss_pRt2;
   logic                    wb_wr, wb_res, iss_v, flush;
   logic [AW:0]             pend_cnt;
`ifdef BW_PRED_BULK_EN
   logic [NPREG-1:0]        bulk_o, bulk_i;
   logic                    bulk_wr;
`endif

   int  n_cmp = 0;
   int  n_bad = 0;
   bit  chk_en = 1'b0;

   logic [NPREG-1:0] m_stor, m_pend;

   always #5 clk = ~clk;

   bw_pred_regfile_fwd #(.NPREG(NPREG), .NRD(NRD), .NFWD(NFWD)) dut (
      .clk(clk), .rst_n(rst_n), .rd_pRn(rd_pRn), .rd_o(rd_o), .rd_rdy(rd_rdy),
      .fwd_pRt1(fwd_pRt1), .fwd_pRt2(fwd_pRt2), .fwd_wr(fwd_wr), .fwd_res(fwd_res),
      .wb_pRt1(wb_pRt1), .wb_pRt2(wb_pRt2), .wb_wr(wb_wr), .wb_res(wb_res),
      .iss_pRt1(iss_pRt1), .iss_pRt2(iss_pRt2), .iss_v(iss_v), .flush(flush),
`ifdef BW_PRED_BULK_EN
      .bulk_o(bulk_o), .bulk_i(bulk_i), .bulk_wr(bulk_wr),
`endif
      .pend_cnt(pend_cnt)
   );

   // Reference model: the architectural register and pending sets.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_stor <= NPREG'(2);
         m_pend <= '0;
      end else begin : upd
         logic [NPREG-1:0] s, p;
         s = m_stor;
         p = m_pend;
         if (wb_wr) begin
            if (wb_pRt2 > 1) s[wb_pRt2] = ~wb_res;
            if (wb_pRt1 > 1) s[wb_pRt1] = wb_res;
         end
         if (flush) p = '0;
         if (wb_wr) begin
            p[wb_pRt1] = 1'b0;
            p[wb_pRt2] = 1'b0;
         end
         if (iss_v) begin
            if (iss_pRt1 > 1) p[iss_pRt1] = 1'b1;
            if (iss_pRt2 > 1) p[iss_pRt2] = 1'b1;
         end
`ifdef BW_PRED_BULK_EN
         if (bulk_wr) begin
            s = bulk_i;
            s[0] = 1'b0;
            s[1] = 1'b1;
            p = '0;
         end
`endif
         m_stor <= s;
         m_pend <= p;
      end
   end

   function automatic void mread(input int n, output bit o, output bit r);
      bit found;
      found = 1'b0;
      o = 1'b0;
      if (n == 0) begin o = 1'b0; found = 1'b1; end
      else if (n == 1) begin o = 1'b1; found = 1'b1; end
      for (int s = 0; s < NFWD; s++)
         if (!found && fwd_wr[s]) begin
            if (n == int'(fwd_pRt1[s])) begin o = fwd_res[s]; found = 1'b1; end
            else if (n == int'(fwd_pRt2[s])) begin o = ~fwd_res[s]; found = 1'b1; end
         end
      if (!found && wb_wr) begin
         if (n == int'(wb_pRt1)) begin o = wb_res; found = 1'b1; end
         else if (n == int'(wb_pRt2)) begin o = ~wb_res; found = 1'b1; end
      end
      if (!found) o = m_stor[n];
      r = found | ~m_pend[n];
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < NRD; i++) begin : prt
            bit eo, er;
            mread(int'(rd_pRn[i]), eo, er);
            chk($sformatf("model_rd_o[%0d]", i), 64'(rd_o[i]), 64'(eo));
            chk($sformatf("model_rd_rdy[%0d]", i), 64'(rd_rdy[i]), 64'(er));
         end
         chk("model_pend_cnt", 64'(pend_cnt), 64'($countones(m_pend)));
`ifdef BW_PRED_BULK_EN
         chk("model_bulk_o", bulk_o, m_stor);
`endif
      end
   end

   task automatic idle();
      fwd_pRt1 = '0; fwd_pRt2 = '0; fwd_wr = '0; fwd_res = '0;
      wb_pRt1 = '0; wb_pRt2 = '0; wb_wr = 1'b0; wb_res = 1'b0;
      iss_pRt1 = '0; iss_pRt2 = '0; iss_v = 1'b0; flush = 1'b0;
`ifdef BW_PRED_BULK_EN
      bulk_i = '0; bulk_wr = 1'b0;
`endif
   endtask

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   task automatic rd3(input int a, input int b, input int c);
      rd_pRn[0] = AW'(a); rd_pRn[1] = AW'(b); rd_pRn[2] = AW'(c);
   endtask

   initial begin
      idle();
      rd3(0, 1, 5);
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // 1: reset state
      settle();
      chk("t1_rd_o", 64'(rd_o), 64'b010);
      chk("t1_rd_rdy", 64'(rd_rdy), 64'b111);
      chk("t1_pend_cnt", 64'(pend_cnt), 64'd0);

      // 2: issue marks pending, stage 1 forwards over it
      iss_v = 1'b1; iss_pRt1 = 5; iss_pRt2 = 6;
      cyc();
      idle(); rd3(5, 6, 0);
      settle();
      chk("t2_rdy_pending", 64'(rd_rdy[0]), 64'd0);
      chk("t2_pend_cnt", 64'(pend_cnt), 64'd2);
      fwd_pRt1[1] = 5; fwd_pRt2[1] = 6; fwd_wr[1] = 1'b1; fwd_res[1] = 1'b1;
      settle();
      chk("t2_fwd_o", 64'(rd_o[1:0]), 64'b01);
      chk("t2_fwd_rdy", 64'(rd_rdy[1:0]), 64'b11);

      // 3: youngest stage wins
      fwd_pRt1[0] = 9; fwd_pRt2[0] = 10; fwd_wr[0] = 1'b1; fwd_res[0] = 1'b0;
      fwd_pRt1[1] = 9; fwd_pRt2[1] = 11; fwd_wr[1] = 1'b1; fwd_res[1] = 1'b1;
      rd3(9, 11, 10);
      settle();
      chk("t3_prio_o", 64'(rd_o), 64'b100);
      idle();
      wb_wr = 1'b1; wb_pRt1 = 5; wb_pRt2 = 6; wb_res = 1'b1;
      cyc();
      idle(); rd3(5, 6, 0);
      settle();
      chk("t3_wb_o", 64'(rd_o), 64'b001);
      chk("t3_wb_cnt", 64'(pend_cnt), 64'd0);

      // 4: writeback and issue of the same register in one cycle
      wb_wr = 1'b1; wb_pRt1 = 7; wb_pRt2 = 7; wb_res = 1'b1;
      iss_v = 1'b1; iss_pRt1 = 7; iss_pRt2 = 8;
      cyc();
      idle(); rd3(7, 8, 0);
      settle();
      chk("t4_stor7", 64'(rd_o[0]), 64'd1);
      chk("t4_rdy", 64'(rd_rdy[1:0]), 64'b00);
      chk("t4_cnt", 64'(pend_cnt), 64'd2);

      // 5: constant registers ignore writes; flush behaviour
      wb_wr = 1'b1; wb_pRt1 = 1; wb_pRt2 = 0; wb_res = 1'b0;
      cyc();
      idle(); rd3(0, 1, 7);
      settle();
      chk("t5_const", 64'(rd_o[1:0]), 64'b10);
      iss_v = 1'b1; iss_pRt1 = 12; iss_pRt2 = 12;
      cyc();
      idle();
      settle();
      chk("t5_cnt3", 64'(pend_cnt), 64'd3);
      flush = 1'b1;
      cyc();
      idle();
      settle();
      chk("t5_flush", 64'(pend_cnt), 64'd0);
      flush = 1'b1; iss_v = 1'b1; iss_pRt1 = 20; iss_pRt2 = 21;
      cyc();
      idle();
      settle();
      chk("t5_flush_iss", 64'(pend_cnt), 64'd2);
      wb_wr = 1'b1; wb_pRt1 = 20; wb_pRt2 = 21; wb_res = 1'b0;
      cyc();
      idle();

      // mid-run reset: state clears, forwarding still live
      fwd_pRt1[0] = 30; fwd_pRt2[0] = 31; fwd_wr[0] = 1'b1; fwd_res[0] = 1'b1;
      rd3(30, 7, 21);
      rst_n = 1'b0;
      settle();
      chk("t5_rst_o", 64'(rd_o), 64'b001);
      chk("t5_rst_rdy", 64'(rd_rdy), 64'b111);
      chk("t5_rst_cnt", 64'(pend_cnt), 64'd0);
      cyc();
      rst_n = 1'b1;
      idle();

`ifdef BW_PRED_BULK_EN
      // 6: bulk load overrides a same-cycle writeback
      wb_wr = 1'b1; wb_pRt1 = 8; wb_pRt2 = 9; wb_res = 1'b1;
      cyc();
      idle();
      iss_v = 1'b1; iss_pRt1 = 40; iss_pRt2 = 41;
      cyc();
      idle();
      bulk_wr = 1'b1; bulk_i = '0;
      wb_wr = 1'b1; wb_pRt1 = 8; wb_pRt2 = 9; wb_res = 1'b1;
      cyc();
      idle(); rd3(8, 9, 1);
      settle();
      chk("t6_bulk_o", bulk_o, 64'h2);
      chk("t6_p8", 64'(rd_o), 64'b100);
      chk("t6_cnt", 64'(pend_cnt), 64'd0);
`endif

      settle();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bw_pred_regfile_fwd.md
Name: bw_pred_regfile_fwd

Overview:
Parametrised predicate register file with integrated forwarding network and pending scoreboard for the BlackWidow core.
- Holds NPREG one-bit predicates. p0 is hardwired to 0 and p1 to 1.
- Serves NRD read ports, each forwarded from NFWD in-flight pipeline stages plus the writeback stage.
- Tracks compare results that have issued but not yet written back, and raises per-port ready so issue logic can stall.
- Each compare writes a dual destination: pRt1 gets res, pRt2 gets ~res.

Parameters:
NPREG, 64, number of predicate registers (power of 2, >=4)
NRD, 3, number of read ports
NFWD, 2, forwarding stages; index 0 is youngest and highest priority
AW, $clog2(NPREG), predicate index width (derived)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rd_pRn  in  NRD x AW  read port predicate index
rd_o  out  NRD  read value (combinational)
rd_rdy  out  NRD  read value valid (combinational)
fwd_pRt1  in  NFWD x AW  stage true-destination index
fwd_pRt2  in  NFWD x AW  stage complement-destination index
fwd_wr  in  NFWD  stage holds a valid predicate result
fwd_res  in  NFWD  stage result
wb_pRt1  in  AW  writeback true-destination index
wb_pRt2  in  AW  writeback complement-destination index
wb_wr  in  1  writeback enable
wb_res  in  1  writeback result
iss_pRt1  in  AW  issuing compare true-destination index
iss_pRt2  in  AW  issuing compare complement-destination index
iss_v  in  1  compare issued this cycle
flush  in  1  discard all pending marks (branch mispredict)
pend_cnt  out  AW+1  registered count of pending predicates

Behaviour:
- Reset (async, rst_n=0):
  - Storage all 0, except p1=1.
  - Pending vector all 0.
  - pend_cnt=0.
  - rd_o and rd_rdy follow combinationally from the reset state.
- Read value priority per port, first match wins:
  1. pRn==0 -> 0
  2. pRn==1 -> 1
  3. For stage s=0..NFWD-1: pRn==fwd_pRt1[s]&&fwd_wr[s] -> fwd_res[s]; else pRn==fwd_pRt2[s]&&fwd_wr[s] -> ~fwd_res[s]
  4. pRn==wb_pRt1&&wb_wr -> wb_res; pRn==wb_pRt2&&wb_wr -> ~wb_res
  5. Storage
- rd_rdy=1 if any of steps 1-4 matched, else ~pending[pRn].
- Read latency is zero cycles; all read paths are purely combinational.
- Write (posedge clk, wb_wr=1):
  - storage[wb_pRt2] <= ~wb_res, then storage[wb_pRt1] <= wb_res. If wb_pRt1==wb_pRt2, pRt1 wins.
  - Writes to index 0 or 1 are ignored in every path.
- Pending update, evaluated in this order within one clock:
  1. flush clears all bits.
  2. wb_wr clears bits wb_pRt1 and wb_pRt2.
  3. iss_v sets bits iss_pRt1 and iss_pRt2.
  - Same register issued and written back in one cycle: set wins (newer owner).
  - Issue during flush: the issue is retained.
  - Bits 0 and 1 are never set.
- pend_cnt <= popcount(next pending vector); it equals the pending population after the edge.
- Mid-operation reset clears pending and storage immediately. Forwarding inputs remain combinationally effective while in reset.
- No handshake. Caller guarantees a predicate is not issued again while its prior producer is still ahead of writeback; behaviour is undefined otherwise.

Optional Feature:
BW_PRED_BULK_EN
- With the macro defined, the block gains three ports:
  - bulk_o (out, NPREG): storage vector.
  - bulk_i (in, NPREG): vector to load.
  - bulk_wr (in, 1): load enable.
- Effect of bulk_wr=1 at the clock:
  - Storage <= bulk_i, with bit0 forced 0 and bit1 forced 1.
  - Pending is cleared and pend_cnt <= 0.
  - Overrides wb_wr and iss_v in the same cycle.
- Purpose: context save/restore.
- Without the macro these ports do not exist and the logic is absent.

Decomposition:
- Shared package rfBlackWidowPkg holds:
  - pred_idx_t (AW-bit typedef)
  - constants PRED_ZERO=0, PRED_ONE=1
  - struct pred_fwd_t {pRt1, pRt2, wr, res}, used for the fwd and wb buses
- One natural sub-module, bw_pred_fwd_sel: the per-port combinational priority selector returning {o, hit}. Instantiate it NRD times via generate.

Test Plan:
1. Reset release -> rd_pRn=0 gives rd_o=0, pRn=1 gives rd_o=1, pRn=5 gives rd_o=0, all rd_rdy=1, pend_cnt=0.
2. iss_v with pRt1=5, pRt2=6; next cycle read 5 -> rd_rdy=0, pend_cnt=2. Then fwd[1]: pRt1=5, pRt2=6, wr=1, res=1 -> port reading 5 gets rd_o=1, rd_rdy=1; port reading 6 gets rd_o=0, rd_rdy=1.
3. fwd[0] (pRt1=9, res=0) and fwd[1] (pRt1=9, res=1) both valid -> read 9 gives rd_o=0 (stage 0 wins).
4. wb_wr with pRt1=7, pRt2=7, res=1 plus same-cycle iss_v with pRt1=7 -> storage[7]=1, pending[7]=1, pend_cnt reflects it.
5. wb_wr with pRt1=1, pRt2=0, res=0 -> reads of p1=1 and p0=0 unchanged. flush with 3 bits pending -> pend_cnt=0 next cycle.
6. (BW_PRED_BULK_EN) bulk_wr with bulk_i=all zeros and a same-cycle wb to p8 -> bulk_o bit1=1, all other bits 0; p8 remains 0.
